// File: rtl/need_sequencer_pkg.sv
// Constants shared by the need sequencer and the pet-state register bank:
// bus widths, value limits, stat addresses and the sequencer FSM encoding.
package need_sequencer_pkg;

   localparam int BIT_ADDR_DEFAULT = 3;
   localparam int BIT_DATO_DEFAULT = 3;
   localparam int MIN_VAL_DEFAULT  = 1;
   localparam int MAX_VAL_DEFAULT  = 5;

   localparam int FEED   = 0;
   localparam int PLAY   = 1;
   localparam int SLEEP  = 2;
   localparam int CLEAN  = 3;
   localparam int HEALTH = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_CHECK  = 2'd2,
      S_SETTLE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/need_sequencer_decay_timer.sv
// Free-running 0..TICK_DIV-1 counter; tick_o is high for the single wrap cycle.
// No backpressure: the tick is a pulse the consumer must latch.
module need_sequencer_decay_timer #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic Reset,
   output logic tick_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!Reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/need_sequencer.sv
// Turns action pulses and periodic decay into bank inc/dec strobes, one stat per 4-cycle pass.
// Strobe lands 2 cycles after a latched request; requests wait in pending bits, never dropped.
module need_sequencer
   import need_sequencer_pkg::*;
#(
   parameter int BIT_ADDR = BIT_ADDR_DEFAULT,
   parameter int BIT_DATO = BIT_DATO_DEFAULT,
   parameter int NSTAT    = 4,
   parameter int TICK_DIV = 50_000_000,
   parameter int MIN_VAL  = MIN_VAL_DEFAULT,
   parameter int MAX_VAL  = MAX_VAL_DEFAULT,
   parameter int LOW_TH   = 2
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic [NSTAT-1:0]    btn_action,
   input  logic [BIT_DATO-1:0] stateValue,
   output logic [BIT_ADDR-1:0] state,
   output logic                UpState,
   output logic                DownState,
   output logic [NSTAT-1:0]    low_mask,
   output logic                dead,
   output logic                busy
);

   localparam logic [BIT_DATO-1:0] MIN_V = BIT_DATO'(MIN_VAL);
   localparam logic [BIT_DATO-1:0] MAX_V = BIT_DATO'(MAX_VAL);
   localparam logic [BIT_DATO-1:0] LOW_V = BIT_DATO'(LOW_TH);

   seq_state_e          fsm_q, fsm_d;
   logic [BIT_ADDR-1:0] addr_q, addr_d;
   logic                is_act_q, is_act_d;
   logic [NSTAT-1:0]    act_pend_q, act_pend_d;
   logic [NSTAT-1:0]    decay_pend_q, decay_pend_d;
   logic [NSTAT-1:0]    low_mask_q, low_mask_d;
   logic                dead_q, dead_d;
   logic [NSTAT-1:0]    clr;
   logic                tick;
   logic                sel_vld, sel_act;
   logic [BIT_ADDR-1:0] sel_idx;

   need_sequencer_decay_timer #(.TICK_DIV(TICK_DIV)) u_decay_timer (
      .clk    (clk),
      .Reset  (Reset),
      .tick_o (tick)
   );

   // Scan downwards so the lowest index wins; actions override decays.
   always_comb begin
      sel_vld = 1'b0;
      sel_act = 1'b0;
      sel_idx = '0;
      for (int i = NSTAT - 1; i >= 0; i--) begin
         if (decay_pend_q[i]) begin
            sel_vld = 1'b1;
            sel_idx = BIT_ADDR'(i);
         end
      end
      for (int i = NSTAT - 1; i >= 0; i--) begin
         if (act_pend_q[i]) begin
            sel_vld = 1'b1;
            sel_act = 1'b1;
            sel_idx = BIT_ADDR'(i);
         end
      end
   end

   always_comb begin
      fsm_d      = fsm_q;
      addr_d     = addr_q;
      is_act_d   = is_act_q;
      low_mask_d = low_mask_q;
      dead_d     = dead_q;
      clr        = '0;
      UpState    = 1'b0;
      DownState  = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            if (sel_vld) begin
               fsm_d    = S_ADDR;
               addr_d   = sel_idx;
               is_act_d = sel_act;
            end
         end
         S_ADDR: fsm_d = S_CHECK;
         S_CHECK: begin
            fsm_d = S_SETTLE;
            if (is_act_q) UpState   = (stateValue >= MIN_V) && (stateValue < MAX_V);
            else          DownState = (stateValue > MIN_V);
            for (int i = 0; i < NSTAT; i++) clr[i] = (addr_q == BIT_ADDR'(i));
         end
         S_SETTLE: begin
            fsm_d = S_IDLE;
            for (int i = 0; i < NSTAT; i++) begin
               if (addr_q == BIT_ADDR'(i)) low_mask_d[i] = (stateValue <= LOW_V);
            end
            if (stateValue == '0) dead_d = 1'b1;
         end
         default: fsm_d = S_IDLE;
      endcase
      if (dead_q) begin
         fsm_d     = S_IDLE;
         UpState   = 1'b0;
         DownState = 1'b0;
      end
   end

   // A pulse arriving during CHECK re-sets the bit being cleared, so it is serviced again.
   always_comb begin
      act_pend_d   = (act_pend_q & ~(clr & {NSTAT{is_act_q}})) | btn_action;
      decay_pend_d = tick ? '1 : (decay_pend_q & ~(clr & {NSTAT{~is_act_q}}));
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         fsm_q        <= S_IDLE;
         addr_q       <= '0;
         is_act_q     <= 1'b0;
         act_pend_q   <= '0;
         decay_pend_q <= '0;
         low_mask_q   <= '0;
         dead_q       <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         addr_q       <= addr_d;
         is_act_q     <= is_act_d;
         act_pend_q   <= act_pend_d;
         decay_pend_q <= decay_pend_d;
         low_mask_q   <= low_mask_d;
         dead_q       <= dead_d;
      end
   end

   assign state    = addr_q;
   assign low_mask = low_mask_q;
   assign dead     = dead_q;
   assign busy     = (fsm_q != S_IDLE);

endmodule

// File: tb/tb_need_sequencer.sv
// Directed bench for need_sequencer with a behavioural register bank; TICK_DIV shortened to 16.
module tb_need_sequencer;
   import need_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       Reset;
   logic [3:0] btn_action;
   logic [2:0] stateValue;
   logic [2:0] state;
   logic       UpState, DownState, dead, busy;
   logic [3:0] low_mask;

   logic [2:0]  bank [0:7];
   logic        load_req;
   logic [11:0] load_val;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int rec_cyc [0:15];
   int rec_adr [0:15];
   bit rec_up  [0:15];
   int rec_n;
   int busy_seen;

   typedef struct {
      int         idx;
      logic [2:0] init;
      logic       exp_up;
      logic [2:0] exp_val;
      logic       exp_low;
   } vec_t;

   vec_t tbl [0:5];

   always #5 clk = ~clk;

   assign stateValue = bank[state];

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 8; i++) bank[i] <= (i < 4) ? load_val[i*3 +: 3] : 3'd5;
      end else if (UpState) begin
         bank[state] <= bank[state] + 3'd1;
      end else if (DownState) begin
         bank[state] <= bank[state] - 3'd1;
      end
   end

   need_sequencer #(
      .BIT_ADDR (3),
      .BIT_DATO (3),
      .NSTAT    (4),
      .TICK_DIV (16),
      .MIN_VAL  (1),
      .MAX_VAL  (5),
      .LOW_TH   (2)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .btn_action (btn_action),
      .stateValue (stateValue),
      .state      (state),
      .UpState    (UpState),
      .DownState  (DownState),
      .low_mask   (low_mask),
      .dead       (dead),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic step_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset(input logic [11:0] vals);
      @(negedge clk);
      Reset      = 1'b0;
      btn_action = '0;
      load_req   = 1'b1;
      load_val   = vals;
      @(negedge clk);
      load_req = 1'b0;
      @(negedge clk);
      Reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic watch(input int to);
      while (cyc < to) begin
         step();
         busy_seen += int'(busy);
         if (UpState || DownState) begin
            chk("strobe_exclusive", UpState & DownState, 0);
            if (rec_n < 16) begin
               rec_cyc[rec_n] = cyc;
               rec_adr[rec_n] = int'(state);
               rec_up[rec_n]  = UpState;
            end
            rec_n++;
         end
      end
   endtask

   function automatic logic [11:0] fill(input logic [2:0] base, input int idx, input logic [2:0] v);
      logic [11:0] r;
      r = {4{base}};
      r[idx*3 +: 3] = v;
      return r;
   endfunction

   initial begin
      int up_cnt;
      int bcnt;

      Reset      = 1'b0;
      btn_action = '0;
      load_req   = 1'b1;
      load_val   = '0;

      tbl[0] = '{SLEEP, 3'd3, 1'b1, 3'd4, 1'b0};
      tbl[1] = '{FEED,  3'd5, 1'b0, 3'd5, 1'b0};
      tbl[2] = '{PLAY,  3'd1, 1'b1, 3'd2, 1'b1};
      tbl[3] = '{CLEAN, 3'd4, 1'b1, 3'd5, 1'b0};
      tbl[4] = '{PLAY,  3'd6, 1'b0, 3'd6, 1'b0};
      tbl[5] = '{FEED,  3'd2, 1'b1, 3'd3, 1'b0};

      // Reset state and first decay pass.
      do_reset({4{3'd6}});
      chk("rst_state", state, 0);
      chk("rst_up", UpState, 0);
      chk("rst_down", DownState, 0);
      chk("rst_low_mask", low_mask, 0);
      chk("rst_dead", dead, 0);
      chk("rst_busy", busy, 0);
      rec_n = 0; busy_seen = 0;
      watch(31);
      chk("decay_pass_count", rec_n, 4);
      for (int k = 0; k < 4 && k < rec_n; k++) begin
         chk("decay_pass_cycle", rec_cyc[k], 18 + 4*k);
         chk("decay_pass_addr", rec_adr[k], k);
         chk("decay_pass_is_down", rec_up[k], 0);
      end
      chk("decay_pass_bank0", bank[0], 5);
      chk("decay_pass_bank3", bank[3], 5);

      // Single action pulses from the table.
      for (int t = 0; t < 6; t++) begin
         do_reset(fill(3'd3, tbl[t].idx, tbl[t].init));
         btn_action = 4'(1 << tbl[t].idx);
         bcnt = 0;
         step(); btn_action = '0; bcnt += int'(busy);
         step(); bcnt += int'(busy);
         chk("act_addr", state, tbl[t].idx);
         chk("act_no_early_up", UpState, 0);
         step(); bcnt += int'(busy);
         chk("act_up", UpState, tbl[t].exp_up);
         chk("act_no_down", DownState, 0);
         step(); bcnt += int'(busy);
         chk("act_settle_quiet", UpState, 0);
         step(); bcnt += int'(busy);
         chk("act_bank_val", bank[tbl[t].idx], tbl[t].exp_val);
         chk("act_low_mask", low_mask, 4'(tbl[t].exp_low) << tbl[t].idx);
         chk("act_dead", dead, 0);
         for (int k = 0; k < 3; k++) begin
            step(); bcnt += int'(busy);
         end
         chk("act_busy_cycles", bcnt, 3);
      end

      // Repeated pulses on a pending bit merge into one increment.
      do_reset(fill(3'd3, FEED, 3'd2));
      btn_action = 4'b0001;
      up_cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 2) btn_action = '0;
         up_cnt += int'(UpState);
      end
      chk("merge_up_count", up_cnt, 1);
      chk("merge_bank", bank[FEED], 3);

      // Pulse during CHECK of the same stat is re-latched and serviced again.
      do_reset(fill(3'd3, SLEEP, 3'd2));
      btn_action = 4'b0100;
      step(); btn_action = '0;
      step_to(3);
      chk("relatch_first_up", UpState, 1);
      btn_action = 4'b0100;
      step(); btn_action = '0;
      rec_n = 0; busy_seen = 0;
      watch(14);
      chk("relatch_second_count", rec_n, 1);
      if (rec_n > 0) chk("relatch_second_cycle", rec_cyc[0], 7);
      chk("relatch_bank", bank[SLEEP], 4);

      // Decay down to MIN_VAL, then no further decrement.
      do_reset(fill(3'd6, PLAY, 3'd2));
      step_to(22);
      chk("min_first_down", DownState, 1);
      chk("min_first_addr", state, PLAY);
      step_to(24);
      chk("min_bank", bank[PLAY], 1);
      chk("min_low_mask", low_mask[PLAY], 1);
      step_to(38);
      chk("min_second_addr", state, PLAY);
      chk("min_second_busy", busy, 1);
      chk("min_second_no_down", DownState, 0);

      // Action during decay of stat 0 jumps ahead of the remaining decays.
      do_reset({4{3'd4}});
      step_to(18);
      chk("preempt_decay0", DownState, 1);
      btn_action = 4'b1000;
      step(); btn_action = '0;
      rec_n = 0; busy_seen = 0;
      watch(30);
      chk("preempt_count", rec_n, 3);
      if (rec_n >= 3) begin
         chk("preempt_up_addr", rec_adr[0], CLEAN);
         chk("preempt_up_kind", rec_up[0], 1);
         chk("preempt_up_cycle", rec_cyc[0], 22);
         chk("preempt_down1_addr", rec_adr[1], PLAY);
         chk("preempt_down2_addr", rec_adr[2], SLEEP);
      end

      // Reset mid-sequence drops the strobe on the next edge.
      do_reset({4{3'd3}});
      btn_action = 4'b0001;
      step(); btn_action = '0;
      step_to(3);
      chk("midrst_up_before", UpState, 1);
      Reset = 1'b0;
      step();
      chk("midrst_up_after", UpState, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_state", state, 0);
      Reset = 1'b1;

      // A zero read makes the sequencer dead until reset.
      do_reset(fill(3'd3, SLEEP, 3'd0));
      btn_action = 4'b0100;
      step(); btn_action = '0;
      step_to(3);
      chk("dead_no_up", UpState, 0);
      step_to(4);
      chk("dead_not_yet", dead, 0);
      step_to(5);
      chk("dead_set", dead, 1);
      btn_action = 4'b0001;
      step(); btn_action = '0;
      rec_n = 0; busy_seen = 0;
      watch(40);
      chk("dead_no_strobes", rec_n, 0);
      chk("dead_never_busy", busy_seen, 0);
      chk("dead_sticky", dead, 1);
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      chk("dead_cleared", dead, 0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
